// File: rtl/hist_accumulator.sv
// Histogram accumulator: bins an 8-bit sample stream into saturating
// counters and dumps them as a framed, clear-on-read byte stream.
module hist_accumulator #(
  parameter int NBINS = 16,
  parameter int BIN_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       dump_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int IW = $clog2(NBINS);
  localparam int PW = $clog2(NBINS + 1);
  localparam logic [PW-1:0] LAST   = PW'(NBINS);
  localparam logic [PW-1:0] LASTM1 = PW'(NBINS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bins_q [NBINS];
  logic [BIN_W-1:0] bins_d [NBINS];
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;

  logic [IW-1:0]    idx;
  logic [PW-1:0]    ptm1;
  logic             hs;

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    idx     = sample_in[7 -: IW];
    ptm1    = ptr_q - 1'b1;
    hs      = (state_q == DUMP) && out_ready;

    unique case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          if (bins_q[idx] == '1) begin
            ovf_d = 1'b1;
          end else begin
            bins_d[idx] = bins_q[idx] + 1'b1;
          end
        end
        // Header sees the flags after this cycle's sample.
        if (dump_req) begin
          state_d = DUMP;
          ptr_d   = '0;
          data_d  = {4'hA, 2'b00, drop_d, ovf_d};
          last_d  = 1'b0;
        end
      end
      DUMP: begin
        if (sample_valid) begin
          drop_d = 1'b1;
        end
        if (hs) begin
          if (ptr_q != '0) begin
            bins_d[ptm1[IW-1:0]] = '0;
          end
          if (ptr_q == LAST) begin
            state_d = ACCUM;
            ptr_d   = '0;
            data_d  = 8'h00;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = sample_valid;
          end else begin
            ptr_d  = ptr_q + 1'b1;
            data_d = bins_q[ptr_q[IW-1:0]];
            last_d = (ptr_q == LASTM1);
          end
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= '0;
      end
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
      ptr_q  <= '0;
      data_q <= 8'h00;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bins_q  <= bins_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == DUMP);
  assign busy      = (state_q == DUMP);
  assign out_last  = last_q;

endmodule

// File: tb/tb_hist_accumulator.sv
// Scoreboard bench for hist_accumulator: a frame-level model pushes
// expected bytes, a negedge monitor pops them on every handshake.
module tb_hist_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       dump_req = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  hist_accumulator #(.NBINS(16), .BIN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .dump_req    (dump_req),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int   mbins[16];
  bit   movf, mdrop, mdump;
  int   rem;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted byte and stall stability.
  exp_t       mon_e;
  logic [7:0] prev_d;
  logic       prev_l;
  bit         stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_d);
        check("stall_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", out_data, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte_data", out_data, mon_e.data);
          check("byte_last", out_last, mon_e.last);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  // Frame-level model: a dump snapshots the whole frame at once.
  task automatic model(bit sv, logic [7:0] s, bit dr, bit rdy);
    int   b;
    exp_t x;
    if (!mdump) begin
      if (sv) begin
        b = int'(s) / 16;
        if (mbins[b] == 255) movf = 1'b1;
        else mbins[b]++;
      end
      if (dr) begin
        x.data = 8'hA0 + (mdrop ? 8'd2 : 8'd0) + (movf ? 8'd1 : 8'd0);
        x.last = 1'b0;
        exp_q.push_back(x);
        for (int i = 0; i < 16; i++) begin
          x.data = 8'(mbins[i]);
          x.last = (i == 15);
          exp_q.push_back(x);
          mbins[i] = 0;
        end
        mdump = 1'b1;
        rem   = 17;
      end
    end else begin
      if (sv) mdrop = 1'b1;
      if (rdy) begin
        rem--;
        if (rem == 0) begin
          mdump = 1'b0;
          movf  = 1'b0;
          mdrop = sv;
        end
      end
    end
  endtask

  task automatic step(bit sv, logic [7:0] s, bit dr, bit rdy);
    @(posedge clk);
    #1;
    check("busy", busy, mdump);
    check("out_valid", out_valid, mdump);
    sample_valid = sv;
    sample_in    = s;
    dump_req     = dr;
    out_ready    = rdy;
    model(sv, s, dr, rdy);
  endtask

  task automatic run_out();
    int n = 0;
    while (mdump && n < 100) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    check("frame_done", mdump, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    dump_req     = 1'b0;
    out_ready    = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    exp_q.delete();
    mbins = '{default: 0};
    movf  = 1'b0;
    mdrop = 1'b0;
    mdump = 1'b0;
    rem   = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat [6];
    pat = '{8'h00, 8'h0F, 8'h10, 8'hFF, 8'hF0, 8'hF7};

    do_reset();

    // Idle dump
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();

    // Binning, then clear-on-read
    foreach (pat[i]) step(1'b1, pat[i], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();

    // Saturation
    for (int i = 0; i < 300; i++) step(1'b1, 8'h35, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();

    // Backpressure with drops; last handshake also carries a sample
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int n = 0; n < 300 && mdump; n++) begin
      bit r;
      r = 1'($urandom % 2);
      step((rem == 1) ? 1'b1 : 1'($urandom % 2), 8'($urandom), 1'b0, r);
    end
    check("bp_frame_done", mdump, 0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();

    // Sample and dump_req together
    step(1'b1, 8'h52, 1'b1, 1'b1);
    run_out();

    // Reset mid-frame
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    run_out();

    // Random traffic, held dump_req included
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom % 2), 8'($urandom),
           ($urandom % 8) == 0, ($urandom % 4) != 0);
    end
    run_out();

    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
